// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer for the Tomasulo RISC-V core.
// Allocates entries at tail, captures CDB results, and retires from head as
// single-cycle commit pulses. A mispredicted branch at the head flushes the
// whole buffer and raises clr_out with the redirect PC.
// Index 0 is the "no dependency" tag and is never allocated.
// Optional build macro: ROB_COMMIT_CNT_EN adds a free-running commit counter.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd_id,
  input  logic                 issue_is_branch,
  input  logic                 issue_pred_taken,
  input  logic [31:0]          issue_alt_pc,
  output logic [ROB_WIDTH-1:0] issue_rob_idx,
  output logic                 rob_full,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_rob_idx,
  input  logic [31:0]          cdb_val,
  input  logic                 cdb_taken,
  input  logic [ROB_WIDTH-1:0] query_idx,
  output logic                 query_ready,
  output logic [31:0]          query_val,
  output logic                 rob_to_rf_commit,
  output logic [4:0]           rob_to_rf_reg_id,
  output logic [31:0]          rob_to_rf_reg_val,
  output logic [ROB_WIDTH-1:0] rob_to_rf_rob_idx,
  output logic                 clr_out,
  output logic [31:0]          clr_pc
`ifdef ROB_COMMIT_CNT_EN
  ,
  output logic [31:0]          commit_cnt
`endif
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH-1:0] CAP = '1;
  localparam logic [ROB_WIDTH-1:0] ONE = ROB_WIDTH'(1);

  // Pointer advance skips the reserved index 0.
  function automatic logic [ROB_WIDTH-1:0] ptr_inc(input logic [ROB_WIDTH-1:0] p);
    return (p == CAP) ? ONE : p + ONE;
  endfunction

  logic [DEPTH-1:0]     busy_q, busy_d, ready_q, ready_d;
  logic [DEPTH-1:0]     br_q, br_d, pred_q, pred_d, taken_q, taken_d;
  logic [4:0]           rd_q [DEPTH];
  logic [4:0]           rd_d [DEPTH];
  logic [31:0]          val_q [DEPTH];
  logic [31:0]          val_d [DEPTH];
  logic [31:0]          alt_q [DEPTH];
  logic [31:0]          alt_d [DEPTH];
  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic                 commit_q, commit_d, clr_q, clr_d;
  logic [4:0]           reg_id_q, reg_id_d;
  logic [31:0]          reg_val_q, reg_val_d, clr_pc_q, clr_pc_d;
  logic [ROB_WIDTH-1:0] rob_idx_q, rob_idx_d;
  logic                 do_issue, do_commit, mispredict;

  assign issue_rob_idx     = tail_q;
  assign rob_full          = (count_q == CAP) && !clr_q;
  assign query_ready       = busy_q[query_idx] && ready_q[query_idx];
  assign query_val         = val_q[query_idx];
  assign rob_to_rf_commit  = commit_q;
  assign rob_to_rf_reg_id  = reg_id_q;
  assign rob_to_rf_reg_val = reg_val_q;
  assign rob_to_rf_rob_idx = rob_idx_q;
  assign clr_out           = clr_q;
  assign clr_pc            = clr_pc_q;

  // Next-state: issue at tail, CDB capture, in-order commit, mispredict flush.
  always_comb begin
    busy_d    = busy_q;
    ready_d   = ready_q;
    br_d      = br_q;
    pred_d    = pred_q;
    taken_d   = taken_q;
    rd_d      = rd_q;
    val_d     = val_q;
    alt_d     = alt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    commit_d  = commit_q;
    clr_d     = clr_q;
    reg_id_d  = reg_id_q;
    reg_val_d = reg_val_q;
    rob_idx_d = rob_idx_q;
    clr_pc_d  = clr_pc_q;
    do_issue   = 1'b0;
    do_commit  = 1'b0;
    mispredict = 1'b0;
    if (rdy_in) begin
      // Commit decisions use registered state, so a CDB write to the head
      // retires on the following edge at the earliest.
      do_commit  = busy_q[head_q] && ready_q[head_q];
      mispredict = do_commit && br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
      do_issue   = issue_valid && (count_q != CAP) && !clr_q;
      commit_d   = do_commit;
      clr_d      = mispredict;
      if (do_commit) begin
        // Branches never write the register file, so their rd goes out as 0.
        reg_id_d  = br_q[head_q] ? 5'd0 : rd_q[head_q];
        reg_val_d = val_q[head_q];
        rob_idx_d = head_q;
      end
      if (mispredict) clr_pc_d = alt_q[head_q];
      if (do_issue) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        br_d[tail_q]    = issue_is_branch;
        pred_d[tail_q]  = issue_pred_taken;
        rd_d[tail_q]    = issue_rd_id;
        alt_d[tail_q]   = issue_alt_pc;
        tail_d          = ptr_inc(tail_q);
      end
      if (cdb_valid && (cdb_rob_idx != '0) && busy_q[cdb_rob_idx]) begin
        val_d[cdb_rob_idx]   = cdb_val;
        taken_d[cdb_rob_idx] = cdb_taken;
        ready_d[cdb_rob_idx] = 1'b1;
      end
      if (do_commit) begin
        busy_d[head_q] = 1'b0;
        head_d         = ptr_inc(head_q);
      end
      case ({do_issue, do_commit})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
      if (mispredict) begin
        busy_d  = '0;
        ready_d = '0;
        head_d  = ONE;
        tail_d  = ONE;
        count_d = '0;
      end
    end
  end

  // Control state and registered commit/flush outputs, async reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q    <= '0;
      ready_q   <= '0;
      head_q    <= ONE;
      tail_q    <= ONE;
      count_q   <= '0;
      commit_q  <= 1'b0;
      clr_q     <= 1'b0;
      reg_id_q  <= '0;
      reg_val_q <= '0;
      rob_idx_q <= '0;
      clr_pc_q  <= '0;
    end else begin
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      commit_q  <= commit_d;
      clr_q     <= clr_d;
      reg_id_q  <= reg_id_d;
      reg_val_q <= reg_val_d;
      rob_idx_q <= rob_idx_d;
      clr_pc_q  <= clr_pc_d;
    end
  end

  // Entry payload; only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk_in) begin
    br_q    <= br_d;
    pred_q  <= pred_d;
    taken_q <= taken_d;
    rd_q    <= rd_d;
    val_q   <= val_d;
    alt_q   <= alt_d;
  end

`ifdef ROB_COMMIT_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign commit_cnt = cnt_q;

  // Counts every commit pulse, flushing branches included; wraps naturally.
  always_comb begin
    cnt_d = cnt_q + {31'd0, do_commit};
  end

  // Commit counter register; survives clr_out, cleared only by reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with ROB_WIDTH = 2 (three usable entries).
module tb_reorder_buffer;

  logic        clk_in, rst_in, rdy_in;
  logic        issue_valid, issue_is_branch, issue_pred_taken;
  logic [4:0]  issue_rd_id;
  logic [31:0] issue_alt_pc;
  logic [1:0]  issue_rob_idx;
  logic        rob_full;
  logic        cdb_valid, cdb_taken;
  logic [1:0]  cdb_rob_idx;
  logic [31:0] cdb_val;
  logic [1:0]  query_idx;
  logic        query_ready;
  logic [31:0] query_val;
  logic        rob_to_rf_commit;
  logic [4:0]  rob_to_rf_reg_id;
  logic [31:0] rob_to_rf_reg_val;
  logic [1:0]  rob_to_rf_rob_idx;
  logic        clr_out;
  logic [31:0] clr_pc;
`ifdef ROB_COMMIT_CNT_EN
  logic [31:0] commit_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  reorder_buffer #(.ROB_WIDTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd_id(issue_rd_id),
    .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken),
    .issue_alt_pc(issue_alt_pc), .issue_rob_idx(issue_rob_idx), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
    .query_idx(query_idx), .query_ready(query_ready), .query_val(query_val),
    .rob_to_rf_commit(rob_to_rf_commit), .rob_to_rf_reg_id(rob_to_rf_reg_id),
    .rob_to_rf_reg_val(rob_to_rf_reg_val), .rob_to_rf_rob_idx(rob_to_rf_rob_idx),
    .clr_out(clr_out), .clr_pc(clr_pc)
`ifdef ROB_COMMIT_CNT_EN
    , .commit_cnt(commit_cnt)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Count one comparison and report it if it misses.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_commit(input string tag, input logic [31:0] rd,
                            input logic [31:0] val, input logic [31:0] idx);
    chk({tag, "_pulse"}, rob_to_rf_commit, 1);
    chk({tag, "_rd"}, rob_to_rf_reg_id, rd);
    chk({tag, "_val"}, rob_to_rf_reg_val, val);
    chk({tag, "_idx"}, rob_to_rf_rob_idx, idx);
  endtask

  task automatic cdb(input logic [1:0] idx, input logic [31:0] val, input logic tk);
    cdb_valid = 1'b1; cdb_rob_idx = idx; cdb_val = val; cdb_taken = tk;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_valid = 0; issue_rd_id = 0; issue_is_branch = 0; issue_pred_taken = 0;
    issue_alt_pc = 0; cdb_valid = 0; cdb_rob_idx = 0; cdb_val = 0; cdb_taken = 0;
    query_idx = 0;
    repeat (2) tick();
    chk("rst_commit", rob_to_rf_commit, 0);
    chk("rst_rd", rob_to_rf_reg_id, 0);
    chk("rst_val", rob_to_rf_reg_val, 0);
    chk("rst_ridx", rob_to_rf_rob_idx, 0);
    chk("rst_clr", clr_out, 0);
    chk("rst_clrpc", clr_pc, 0);
    chk("rst_tail", issue_rob_idx, 1);
    chk("rst_full", rob_full, 0);
    rst_in = 1'b0;

    // Fill the buffer: indices 1, 2, 3, then full.
    issue_valid = 1; issue_rd_id = 5; #1;
    chk("alloc1", issue_rob_idx, 1);
    tick(); chk("alloc2", issue_rob_idx, 2); issue_rd_id = 6;
    tick(); chk("alloc3", issue_rob_idx, 3); chk("notfull", rob_full, 0); issue_rd_id = 7;
    tick(); chk("full", rob_full, 1); chk("tail_wrap", issue_rob_idx, 1); issue_rd_id = 8;
    tick(); chk("full_hold", rob_full, 1); chk("ign_issue", issue_rob_idx, 1);
    issue_valid = 0; query_idx = 1; #1;
    chk("q1_notready", query_ready, 0);

    // Out-of-order CDB, in-order commit.
    cdb(2, 32'h22, 0);
    tick(); chk("ooo_nocommit", rob_to_rf_commit, 0);
    query_idx = 2; #1;
    chk("q2_ready", query_ready, 1); chk("q2_val", query_val, 32'h22);
    cdb(1, 32'h11, 0);
    tick(); chk("head_wait", rob_to_rf_commit, 0);
    cdb_valid = 0;
    tick(); chk_commit("c1", 5, 32'h11, 1); chk("full_drop", rob_full, 0);
    tick(); chk_commit("c2", 6, 32'h22, 2);
    tick(); chk("c_idle", rob_to_rf_commit, 0);

    // Wrap: reuse indices 1 and 2.
    issue_valid = 1; issue_rd_id = 9; #1;
    chk("wrap_idx1", issue_rob_idx, 1);
    tick(); chk("wrap_idx2", issue_rob_idx, 2); issue_rd_id = 10;
    tick(); issue_valid = 0; chk("wrap_tail", issue_rob_idx, 3); chk("wrap_full", rob_full, 1);
    cdb(3, 32'h33, 0);
    tick(); chk("w_nocommit", rob_to_rf_commit, 0);
    cdb(1, 32'h44, 0);
    tick(); chk_commit("w3", 7, 32'h33, 3);
    cdb(2, 32'h55, 0);
    tick(); chk_commit("w1", 9, 32'h44, 1);
    cdb_valid = 0;
    tick(); chk_commit("w2", 10, 32'h55, 2);
    tick(); chk("w_idle", rob_to_rf_commit, 0); chk("w_tail", issue_rob_idx, 3);

    // Mispredicted branch at head (index 3) with two younger entries.
    issue_valid = 1; issue_is_branch = 1; issue_pred_taken = 0;
    issue_alt_pc = 32'h1000; issue_rd_id = 0;
    tick(); issue_is_branch = 0; issue_rd_id = 11;
    tick(); issue_rd_id = 12;
    tick(); issue_valid = 0; chk("mp_full", rob_full, 1);
    cdb(3, 32'h0, 1);
    tick(); chk("mp_nocommit", rob_to_rf_commit, 0); chk("mp_noclr", clr_out, 0);
    cdb(1, 32'h99, 0);
    tick(); cdb_valid = 0;
    chk("mp_clr", clr_out, 1); chk("mp_clrpc", clr_pc, 32'h1000);
    chk_commit("mp", 0, 32'h0, 3);
    chk("mp_tail", issue_rob_idx, 1); chk("mp_fullmask", rob_full, 0);
    query_idx = 1; #1;
    chk("mp_q1_cleared", query_ready, 0);
    issue_valid = 1; issue_rd_id = 14;
    tick(); issue_valid = 0;
    chk("mp_clr_done", clr_out, 0); chk("mp_commit_done", rob_to_rf_commit, 0);
    chk("mp_issue_blocked", issue_rob_idx, 1);

    // Stall with rdy_in low while a commit pulse is up and the next head is ready.
    issue_valid = 1; issue_rd_id = 4;
    tick(); issue_rd_id = 3;
    tick(); issue_valid = 0; cdb(1, 32'hA1, 0);
    tick(); cdb(2, 32'hA2, 0);
    tick(); cdb_valid = 0;
    chk_commit("s1", 4, 32'hA1, 1);
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pulse", rob_to_rf_commit, 1);
      chk("stall_idx", rob_to_rf_rob_idx, 1);
    end
    rdy_in = 1;
    tick(); chk_commit("s2", 3, 32'hA2, 2);
    tick(); chk("s_idle", rob_to_rf_commit, 0);

    // Asynchronous reset in the middle of a commit pulse.
    issue_valid = 1; issue_rd_id = 2; #1;
    chk("r_alloc", issue_rob_idx, 3);
    tick(); issue_valid = 0; cdb(3, 32'h77, 0);
    tick(); cdb_valid = 0;
    tick(); chk_commit("r3", 2, 32'h77, 3);
    #2 rst_in = 1; #1;
    chk("ar_commit", rob_to_rf_commit, 0);
    chk("ar_rd", rob_to_rf_reg_id, 0);
    chk("ar_ridx", rob_to_rf_rob_idx, 0);
    chk("ar_tail", issue_rob_idx, 1);
    chk("ar_full", rob_full, 0);
    rst_in = 0;
    tick(); chk("ar_idle", rob_to_rf_commit, 0);
    query_idx = 3; #1;
    chk("ar_q3", query_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
